// File: rtl/rv_imem_loader.sv
// Instruction memory loader: turns a byte stream (2-byte LE word count N, then 4*N LE instruction bytes)
// into writes on port A of the instruction dpram, holding the core in reset while a session runs.
// Latency: one WR cycle after the 4th byte of each word, so at least 5 cycles per word.
// Backpressure: rx_ready_o is high only while a length or data byte can be taken (LEN0/LEN1/DATA).
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start_i             1-cycle pulse that starts a session (ignored while busy)
//   rx_valid_i/_data_i  incoming byte, accepted when rx_valid_i && rx_ready_o
//   rx_ready_o          byte can be accepted this cycle
//   wena_o/addra_o/dina_o  dpram port A write (registered; addra_o holds between writes)
//   busy_o, cpu_hold_o  session in progress / core reset hold
//   done_o, err_o       1-cycle pulses: session finished, or aborted because N > DEPTH
module rv_imem_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          rx_valid_i,
    input  logic [7:0]    rx_data_i,
    output logic          rx_ready_o,
    output logic          wena_o,
    output logic [AW-1:0] addra_o,
    output logic [31:0]   dina_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          cpu_hold_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WR,
        S_FIN
    } state_t;

    localparam logic [15:0]   DEPTH16 = 16'(DEPTH);
    localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [15:0]   n_q, n_d;
    logic [1:0]    k_q, k_d;
    logic [23:0]   word_q, word_d;      // bytes 0..2 of the word being assembled
    logic [AW-1:0] widx_q, widx_d;      // index of the next word to write
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   din_q, din_d;
    logic          wena_q, wena_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          accept;
    logic [15:0]   n_full;
    logic          last_word;

    assign rx_ready_o = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
    assign accept     = rx_valid_i && rx_ready_o;
    assign n_full     = {rx_data_i, n_q[7:0]};
    // Word index is zero-extended; it cannot wrap before the last word since N <= DEPTH.
    assign last_word  = ({{(16-AW){1'b0}}, widx_q} == (n_q - 16'd1));

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        word_d  = word_q;
        widx_d  = widx_q;
        addr_d  = addr_q;
        din_d   = din_q;
        wena_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LEN0;
                    n_d     = 16'd0;
                    k_d     = 2'd0;
                    word_d  = 24'd0;
                    widx_d  = '0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    n_d[7:0] = rx_data_i;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    n_d[15:8] = rx_data_i;
                    if (n_full == 16'd0) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else if (n_full > DEPTH16) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    k_d = k_q + 2'd1;
                    case (k_q)
                        2'd0: word_d[7:0]   = rx_data_i;
                        2'd1: word_d[15:8]  = rx_data_i;
                        2'd2: word_d[23:16] = rx_data_i;
                        default: begin
                            // Fourth byte completes the word: load the write port for WR.
                            din_d   = {rx_data_i, word_q};
                            addr_d  = widx_q;
                            wena_d  = 1'b1;
                            state_d = S_WR;
                        end
                    endcase
                end
            end
            S_WR: begin
                widx_d = widx_q + IDX_ONE;
                if (last_word) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= 16'd0;
            k_q     <= 2'd0;
            word_q  <= 24'd0;
            widx_q  <= '0;
            addr_q  <= '0;
            din_q   <= 32'd0;
            wena_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            word_q  <= word_d;
            widx_q  <= widx_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wena_q  <= wena_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wena_o     = wena_q;
    assign addra_o    = addr_q;
    assign dina_o     = din_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign busy_o     = (state_q != S_IDLE);
    assign cpu_hold_o = busy_o;

endmodule
